// File: rtl/conv_stream_feeder.sv
// Streams a KSIZE x KSIZE kernel, then an N x N frame, from a 1-cycle sync memory to conv_top.
// Optional border padding of the frame is built when CONV_FEEDER_ZERO_PAD_EN is defined.
module conv_stream_feeder #(
    parameter int ADDR_W      = 12,
    parameter int KSIZE       = 3,
    parameter int MAX_IMG     = 32,
    parameter int WEIGHT_BASE = 0,
    parameter int DATA_BASE   = 64,
    parameter int GAP_CYCLES  = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [8:0]        image_size,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [15:0]       mem_rd_data,
    output logic              pi_weight_valid,
    output logic [15:0]       pi_weight,
    output logic              pi_data_valid,
    output logic [15:0]       pi_data
);

    localparam int IDX_W = $clog2(MAX_IMG + 2);
    localparam int CNT_W = $clog2(KSIZE * KSIZE + GAP_CYCLES + 1);
    localparam logic [8:0]       MAX_N  = 9'(MAX_IMG);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(KSIZE * KSIZE - 1);
    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, GAP, LOAD_D, DRAIN, FIN} state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  n_q, row, col, lim;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] ptr;
    logic              err_q, bad_size, at_end, border;
    logic              w_d1, d_d1, z_d1;

    assign bad_size = (image_size == '0) || (image_size > MAX_N);
    assign at_end   = (row == lim) && (col == lim);

`ifdef CONV_FEEDER_ZERO_PAD_EN
    // Grid is (N+2)x(N+2); its outer ring is emitted as zeros without a read.
    assign lim    = n_q + IDX_W'(1);
    assign border = (row == '0) || (col == '0) || (row == lim) || (col == lim);
`else
    assign lim    = n_q - IDX_W'(1);
    assign border = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (start) state_next = bad_size ? FIN : LOAD_W;
            LOAD_W: if (cnt == W_LAST) state_next = GAP;
            GAP:    if (cnt == G_LAST) state_next = LOAD_D;
            LOAD_D: if (at_end) state_next = DRAIN;
            DRAIN:  if (!d_d1) state_next = FIN;
            FIN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        done        = (state == FIN);
        err         = (state == FIN) && err_q;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        if (state == LOAD_W) begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = ADDR_W'(WEIGHT_BASE) + ADDR_W'(cnt);
        end else if (state == LOAD_D && !border) begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = ptr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt   <= '0;
            n_q   <= '0;
            err_q <= 1'b0;
            row   <= '0;
            col   <= '0;
            ptr   <= '0;
        end else begin
            cnt <= (state_next != state) ? '0 : cnt + 1'b1;
            if (state == IDLE) begin
                row <= '0;
                col <= '0;
                ptr <= ADDR_W'(DATA_BASE);
                if (start) begin
                    n_q   <= IDX_W'(image_size);
                    err_q <= bad_size;
                end
            end else if (state == LOAD_D) begin
                // Row-major walk; the address pointer only advances on real reads.
                if (col == lim) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (!border) ptr <= ptr + 1'b1;
            end
        end
    end

    // Two-stage output pipeline: stage 1 waits for read data, stage 2 registers it with its valid.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            w_d1            <= 1'b0;
            d_d1            <= 1'b0;
            z_d1            <= 1'b0;
            pi_weight_valid <= 1'b0;
            pi_weight       <= '0;
            pi_data_valid   <= 1'b0;
            pi_data         <= '0;
        end else begin
            w_d1            <= (state == LOAD_W);
            d_d1            <= (state == LOAD_D);
            z_d1            <= (state == LOAD_D) && border;
            pi_weight_valid <= w_d1;
            pi_data_valid   <= d_d1;
            if (w_d1) pi_weight <= mem_rd_data;
            if (d_d1) pi_data   <= z_d1 ? 16'h0000 : mem_rd_data;
        end
    end

endmodule

// File: doc/conv_stream_feeder.md
Name: conv_stream_feeder

Overview:
- Source-side sequencer that drives the weight/data stream ports of conv_top.
- On a start pulse it reads a KSIZE x KSIZE kernel from a 1-cycle-latency sync memory and emits it as a pi_weight_valid/pi_weight burst.
- After GAP_CYCLES idle cycles it emits the image_size x image_size frame, row-major, as a pi_data_valid/pi_data burst.
- All samples are Q8.8 16-bit and pass through unchanged.

Parameters:
- ADDR_W, 12, memory address width.
- KSIZE, 3, kernel side; the weight burst length is KSIZE*KSIZE.
- MAX_IMG, 32, largest legal image_size.
- WEIGHT_BASE, 0, address of the first weight.
- DATA_BASE, 64, address of pixel (0,0).
- GAP_CYCLES, 4, idle cycles between the last weight valid and the first data valid.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle command pulse.
- image_size  in  9  frame side N; sampled on the accepted start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at the end of a job.
- err  out  1  one-cycle pulse, coincident with done, for a rejected job.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_W  memory read address.
- mem_rd_data  in  16  read data, valid on the cycle after mem_rd_en.
- pi_weight_valid  out  1  weight stream valid.
- pi_weight  out  16  weight sample.
- pi_data_valid  out  1  pixel stream valid.
- pi_data  out  16  pixel sample.

Behaviour:
- Reset values: every output is 0 and the FSM is in IDLE. Reset mid-job aborts immediately; no done pulse is produced.
- FSM states: IDLE, LOAD_W, GAP, LOAD_D, DRAIN, FIN.
- IDLE:
  - start=1 latches N=image_size and sets busy.
  - If N==0 or N>MAX_IMG, go to FIN with err=1; no reads are issued.
  - Otherwise go to LOAD_W.
- LOAD_W:
  - One read per cycle, mem_rd_en=1, addresses WEIGHT_BASE .. WEIGHT_BASE+KSIZE*KSIZE-1.
  - After the last read, go to GAP.
- GAP: count GAP_CYCLES cycles, measured from the cycle after the last weight valid; then go to LOAD_D.
- LOAD_D:
  - One read per cycle, addresses DATA_BASE+r*N+c, with c the inner loop and r the outer loop.
  - The address comes from an incrementing pointer; no multiplier.
  - After the N*N-th read, go to DRAIN.
- DRAIN: wait until the final pi_data_valid has been emitted, then go to FIN.
- FIN: done=1 for one cycle, busy falls on the same edge, then go to IDLE.
- Output latency:
  - A read issued on cycle t gives mem_rd_data sampled on t+1.
  - That data is registered onto pi_weight/pi_data with its valid asserted on cycle t+2.
  - Valid is a registered, two-stage delayed copy of the rd_en of the matching burst type.
- Bursts are gapless: KSIZE*KSIZE consecutive weight valids, then exactly N*N consecutive data valids.
- pi_weight_valid and pi_data_valid are never high in the same cycle.
- Between valids, pi_weight and pi_data hold their last value.
- start while busy is ignored, including on the FIN cycle. A new job may start on the cycle after FIN.
- Address arithmetic is modulo 2^ADDR_W (wraps). The frame size is computed in 11 bits: N*N ≤ 1024.

Optional Feature:
- Macro: CONV_FEEDER_ZERO_PAD_EN.
- When defined, LOAD_D walks an (N+2)x(N+2) grid.
  - Border positions emit pi_data=16'h0000 with pi_data_valid=1 and no memory read.
  - The zero travels through the same 2-stage pipeline, so timing is unchanged.
  - Interior positions read DATA_BASE+(r-1)*N+(c-1).
  - Data burst length is (N+2)^2.
- When undefined, only the N*N burst is emitted and no padding logic is built.

Test Plan:
- N=5, memory weight[i]=16'h0200, pixel[i]=16'hFC00, default parameters, start pulse:
  - 9 weight valids at 16'h0200.
  - Exactly 4 idle cycles.
  - 25 data valids at 16'hFC00.
  - done one cycle after the last data valid; busy spans the job.
- N=3, memory value = address:
  - pi_weight sequence is 0..8.
  - pi_data sequence is 64..72.
  - The first weight valid appears 2 cycles after the first mem_rd_en.
- N=0, then N=33: done and err pulse together, mem_rd_en never asserts, and no valids.
- start re-pulsed mid-LOAD_D with N=7: ignored; the job completes with 25 data valids for the original N=5.
- sys_rst_n dropped during GAP:
  - All outputs clear at once; no done pulse.
  - After release, a new start with N=2 runs cleanly (9+4 valids).
- CONV_FEEDER_ZERO_PAD_EN defined, N=2, pixels 1..4:
  - 16 data valids: 0,0,0,0, 0,1,2,0, 0,3,4,0, 0,0,0,0.
  - Exactly 4 memory reads in the data phase.
